// File: rtl/pu_riscv_if_fetch_ctrl.sv
// Fetch-request sequencer between the instruction-fetch stage and the
// instruction memory port. Issues in-order parcel requests, tracks up to
// DEPTH outstanding requests with a PC queue, and drops responses orphaned
// by flushes.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | just out of reset, no requests
// FETCH | issuing requests at if_nxt_pc, delivering responses
// ERROR | misaligned PC or response error seen; drain only, wait flush
module pu_riscv_if_fetch_ctrl #(
  parameter int XLEN        = 64,
  parameter int PARCEL_SIZE = 32,
  parameter int DEPTH       = 2
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [XLEN-1:0]           if_nxt_pc,
  input  logic                      if_stall,
  input  logic                      if_flush,
  output logic                      if_stall_nxt_pc,
  output logic [PARCEL_SIZE-1:0]    if_parcel,
  output logic [XLEN-1:0]           if_parcel_pc,
  output logic [PARCEL_SIZE/16-1:0] if_parcel_valid,
  output logic                      if_parcel_misaligned,
  output logic                      if_parcel_page_fault,
  output logic                      mem_req,
  output logic [XLEN-1:0]           mem_adr,
  input  logic                      mem_ack,
  input  logic                      mem_rvalid,
  input  logic [PARCEL_SIZE-1:0]    mem_rdata,
  input  logic                      mem_rerr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int VW = PARCEL_SIZE / 16;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_ERROR} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            out_cnt_q, out_cnt_d;
  logic [CW-1:0]            disc_cnt_q, disc_cnt_d;
  logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [XLEN-1:0]          pc_fifo_q [DEPTH];
  logic [XLEN-1:0]          pc_fifo_d [DEPTH];
  logic                     hold_q, hold_d;
  logic [XLEN-1:0]          hold_adr_q, hold_adr_d;
  logic [PARCEL_SIZE-1:0]   parcel_q, parcel_d;
  logic [XLEN-1:0]          parcel_pc_q, parcel_pc_d;
  logic [VW-1:0]            parcel_valid_q, parcel_valid_d;
  logic                     parcel_mis_q, parcel_mis_d;
  logic                     parcel_pf_q, parcel_pf_d;

  logic pc_aligned;
  logic rsp_pop;
  logic rsp_live;
  logic err_rsp;
  logic mis_fire;
  logic new_req;
  logic accept;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + PW'(1);
  endfunction

  // Request/response qualifiers shared by the FSM and the datapath
  always_comb begin
    pc_aligned = (if_nxt_pc[1:0] == 2'b00);
    rsp_pop    = mem_rvalid & (out_cnt_q != '0);
    rsp_live   = rsp_pop & (disc_cnt_q == '0) & ~if_flush;
    err_rsp    = rsp_live & mem_rerr;
    // Misaligned PC is reported only once every non-stale response has drained
    mis_fire   = (state_q == ST_FETCH) & ~hold_q & ~if_flush & ~pc_aligned &
                 (out_cnt_q == disc_cnt_q);
    new_req    = (state_q == ST_FETCH) & ~hold_q & ~if_flush & ~if_stall &
                 pc_aligned & ~err_rsp & (out_cnt_q < DEPTH_C);
    accept     = mem_req & mem_ack;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = ST_FETCH;
      ST_FETCH: if (!if_flush && (mis_fire || err_rsp)) state_d = ST_ERROR;
      ST_ERROR: if (if_flush) state_d = ST_FETCH;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Memory request outputs; a held request ignores stall and only a flush withdraws it
  always_comb begin
    mem_req         = (hold_q & ~if_flush) | new_req;
    mem_adr         = hold_q ? hold_adr_q : ((state_q == ST_FETCH) ? if_nxt_pc : '0);
    if_stall_nxt_pc = ~(mem_req & mem_ack);
  end

  // Outstanding/discard tracking, PC queue and parcel delivery
  always_comb begin
    out_cnt_d = out_cnt_q;
    case ({accept, rsp_pop})
      2'b10:   out_cnt_d = out_cnt_q + CW'(1);
      2'b01:   out_cnt_d = out_cnt_q - CW'(1);
      default: out_cnt_d = out_cnt_q;
    endcase

    // Everything still in flight after a flush (including a same-cycle accept) is stale
    disc_cnt_d = disc_cnt_q;
    if (if_flush)                             disc_cnt_d = out_cnt_d;
    else if (rsp_pop && disc_cnt_q != '0)     disc_cnt_d = disc_cnt_q - CW'(1);

    pc_fifo_d = pc_fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (accept) begin
      pc_fifo_d[wr_ptr_q] = mem_adr;
      wr_ptr_d            = ptr_inc(wr_ptr_q);
    end
    if (rsp_pop) rd_ptr_d = ptr_inc(rd_ptr_q);

    hold_d     = mem_req & ~mem_ack;
    hold_adr_d = mem_req ? mem_adr : hold_adr_q;

    parcel_d       = parcel_q;
    parcel_pc_d    = parcel_pc_q;
    parcel_valid_d = '0;
    parcel_mis_d   = parcel_mis_q;
    parcel_pf_d    = parcel_pf_q;
    if (rsp_live) begin
      parcel_d       = mem_rdata;
      parcel_pc_d    = pc_fifo_q[rd_ptr_q];
      parcel_valid_d = '1;
      parcel_mis_d   = 1'b0;
      parcel_pf_d    = mem_rerr;
    end else if (mis_fire) begin
      parcel_d       = '0;
      parcel_pc_d    = if_nxt_pc;
      parcel_valid_d = '1;
      parcel_mis_d   = 1'b1;
      parcel_pf_d    = 1'b0;
    end
  end

  // Tracking and output registers
  always_ff @(posedge clk) begin
    if (!rstn) begin
      out_cnt_q      <= '0;
      disc_cnt_q     <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      hold_q         <= 1'b0;
      hold_adr_q     <= '0;
      parcel_q       <= '0;
      parcel_pc_q    <= '0;
      parcel_valid_q <= '0;
      parcel_mis_q   <= 1'b0;
      parcel_pf_q    <= 1'b0;
    end else begin
      out_cnt_q      <= out_cnt_d;
      disc_cnt_q     <= disc_cnt_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      hold_q         <= hold_d;
      hold_adr_q     <= hold_adr_d;
      parcel_q       <= parcel_d;
      parcel_pc_q    <= parcel_pc_d;
      parcel_valid_q <= parcel_valid_d;
      parcel_mis_q   <= parcel_mis_d;
      parcel_pf_q    <= parcel_pf_d;
    end
  end

  // PC queue storage; validity is tracked by the pointers and counters
  always_ff @(posedge clk) begin
    pc_fifo_q <= pc_fifo_d;
  end

  assign if_parcel            = parcel_q;
  assign if_parcel_pc         = parcel_pc_q;
  assign if_parcel_valid      = parcel_valid_q;
  assign if_parcel_misaligned = parcel_mis_q;
  assign if_parcel_page_fault = parcel_pf_q;

endmodule

// File: tb/tb_pu_riscv_if_fetch_ctrl.sv
// Bench for pu_riscv_if_fetch_ctrl: directed vector table, hand-written
// corner sequences, then randomized traffic against a queue-based model.
module tb_pu_riscv_if_fetch_ctrl;

  localparam int XLEN  = 64;
  localparam int PS    = 32;
  localparam int DEPTH = 2;

  logic            clk = 1'b1;
  logic            rstn;
  logic [XLEN-1:0] if_nxt_pc;
  logic            if_stall;
  logic            if_flush;
  logic            if_stall_nxt_pc;
  logic [PS-1:0]   if_parcel;
  logic [XLEN-1:0] if_parcel_pc;
  logic [1:0]      if_parcel_valid;
  logic            if_parcel_misaligned;
  logic            if_parcel_page_fault;
  logic            mem_req;
  logic [XLEN-1:0] mem_adr;
  logic            mem_ack;
  logic            mem_rvalid;
  logic [PS-1:0]   mem_rdata;
  logic            mem_rerr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pu_riscv_if_fetch_ctrl #(.XLEN(XLEN), .PARCEL_SIZE(PS), .DEPTH(DEPTH)) dut (
    .clk                  (clk),
    .rstn                 (rstn),
    .if_nxt_pc            (if_nxt_pc),
    .if_stall             (if_stall),
    .if_flush             (if_flush),
    .if_stall_nxt_pc      (if_stall_nxt_pc),
    .if_parcel            (if_parcel),
    .if_parcel_pc         (if_parcel_pc),
    .if_parcel_valid      (if_parcel_valid),
    .if_parcel_misaligned (if_parcel_misaligned),
    .if_parcel_page_fault (if_parcel_page_fault),
    .mem_req              (mem_req),
    .mem_adr              (mem_adr),
    .mem_ack              (mem_ack),
    .mem_rvalid           (mem_rvalid),
    .mem_rdata            (mem_rdata),
    .mem_rerr             (mem_rerr)
  );

  typedef struct {
    logic            rstn, stall, flush, ack, rvalid, rerr;
    logic [XLEN-1:0] pc;
    logic [PS-1:0]   rdata;
    bit              chk;
    logic            req;
    logic [XLEN-1:0] adr;
    logic            stalln;
    logic [1:0]      valid;
    logic [XLEN-1:0] ppc;
    logic [PS-1:0]   pdata;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic st, input logic fl, input logic ak,
                       input logic rv, input logic re, input logic [63:0] pc,
                       input logic [31:0] rd);
    rstn = r; if_stall = st; if_flush = fl; mem_ack = ak;
    mem_rvalid = rv; mem_rerr = re; if_nxt_pc = pc; mem_rdata = rd;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Two reset edges, then one edge out of reset: DUT sits in FETCH afterwards
  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 64'h8000_0000, 0);
    step();
    step();
    drive(1, 0, 0, 0, 0, 0, 64'h8000_0000, 0);
    step();
  endtask

  // Behavioural model state for the random phase
  localparam int M_IDLE = 0, M_FETCH = 1, M_ERR = 2;
  int              m_mode;
  logic [63:0]     m_pcq [$];
  int              m_disc;
  bit              m_hold;
  logic [63:0]     m_hadr;
  logic [1:0]      e_v;
  logic [63:0]     e_pc;
  logic [31:0]     e_data;
  logic            e_mis, e_pf;
  logic [63:0]     fpc;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    drive(0, 0, 0, 1, 0, 0, 64'h8000_0000, 0);

    //          rstn st fl ak rv re pc                 rdata  chk req adr                stn valid ppc                pdata
    tbl[0] = '{0, 0, 0, 1, 0, 0, 64'h8000_0000, 32'h0,  0, 0, 64'h0,          1, 2'b00, 64'h0,          32'h0};
    tbl[1] = '{0, 0, 0, 1, 0, 0, 64'h8000_0000, 32'h0,  1, 0, 64'h0,          1, 2'b00, 64'h0,          32'h0};
    tbl[2] = '{0, 0, 0, 1, 0, 0, 64'h8000_0000, 32'h0,  1, 0, 64'h0,          1, 2'b00, 64'h0,          32'h0};
    tbl[3] = '{1, 0, 0, 1, 0, 0, 64'h8000_0000, 32'h0,  1, 0, 64'h0,          1, 2'b00, 64'h0,          32'h0};
    tbl[4] = '{1, 0, 0, 1, 0, 0, 64'h8000_0000, 32'h0,  1, 1, 64'h8000_0000,  0, 2'b00, 64'h0,          32'h0};
    tbl[5] = '{1, 0, 0, 1, 1, 0, 64'h8000_0004, 32'h13, 1, 1, 64'h8000_0004,  0, 2'b00, 64'h0,          32'h0};
    tbl[6] = '{1, 1, 0, 1, 1, 0, 64'h8000_0008, 32'h93, 1, 0, 64'h8000_0008,  1, 2'b11, 64'h8000_0000,  32'h13};
    tbl[7] = '{1, 1, 0, 1, 0, 0, 64'h8000_0008, 32'h0,  1, 0, 64'h8000_0008,  1, 2'b11, 64'h8000_0004,  32'h93};
    tbl[8] = '{1, 1, 0, 1, 0, 0, 64'h8000_0008, 32'h0,  1, 0, 64'h8000_0008,  1, 2'b00, 64'h8000_0004,  32'h93};

    // Reset and in-order back-to-back delivery
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rstn, tbl[i].stall, tbl[i].flush, tbl[i].ack, tbl[i].rvalid,
            tbl[i].rerr, tbl[i].pc, tbl[i].rdata);
      sample();
      if (tbl[i].chk) begin
        chk($sformatf("tbl%0d_req", i), mem_req, tbl[i].req);
        chk($sformatf("tbl%0d_adr", i), mem_adr, tbl[i].adr);
        chk($sformatf("tbl%0d_stall_nxt", i), if_stall_nxt_pc, tbl[i].stalln);
        chk($sformatf("tbl%0d_valid", i), if_parcel_valid, tbl[i].valid);
        chk($sformatf("tbl%0d_ppc", i), if_parcel_pc, tbl[i].ppc);
        chk($sformatf("tbl%0d_parcel", i), if_parcel, tbl[i].pdata);
        chk($sformatf("tbl%0d_mis", i), if_parcel_misaligned, 1'b0);
        chk($sformatf("tbl%0d_pf", i), if_parcel_page_fault, 1'b0);
      end
      step();
    end

    // Outstanding limit: req drops after DEPTH accepts, response re-enables it
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0000, 0); sample();
    chk("lim_req1", mem_req, 1'b1); chk("lim_stn1", if_stall_nxt_pc, 1'b0); step();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0004, 0); sample();
    chk("lim_req2", mem_req, 1'b1); chk("lim_adr2", mem_adr, 64'h8000_0004); step();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0008, 0); sample();
    chk("lim_req_full", mem_req, 1'b0); chk("lim_stn_full", if_stall_nxt_pc, 1'b1); step();
    drive(1, 0, 0, 1, 1, 0, 64'h8000_0008, 32'hAA); sample();
    chk("lim_req_rsp", mem_req, 1'b0); step();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0008, 0); sample();
    chk("lim_req_again", mem_req, 1'b1); chk("lim_adr_again", mem_adr, 64'h8000_0008);
    chk("lim_valid", if_parcel_valid, 2'b11); chk("lim_ppc", if_parcel_pc, 64'h8000_0000);
    chk("lim_data", if_parcel, 32'hAA); step();
    drive(1, 0, 0, 0, 1, 0, 64'h8000_000C, 32'hBB); sample();
    chk("lim_req_full2", mem_req, 1'b0); step();
    drive(1, 0, 0, 0, 1, 0, 64'h8000_000C, 32'hCC); sample();
    chk("lim_ppc2", if_parcel_pc, 64'h8000_0004); chk("lim_data2", if_parcel, 32'hBB); step();
    drive(1, 0, 0, 0, 0, 0, 64'h8000_000C, 0); sample();
    chk("lim_ppc3", if_parcel_pc, 64'h8000_0008); chk("lim_data3", if_parcel, 32'hCC);
    chk("lim_valid3", if_parcel_valid, 2'b11); step();

    // Flush with two outstanding: both old responses dropped, resume at new PC
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0000, 0); sample(); chk("fl_req1", mem_req, 1'b1); step();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0004, 0); sample(); chk("fl_req2", mem_req, 1'b1); step();
    drive(1, 0, 1, 1, 0, 0, 64'h8000_0008, 0); sample();
    chk("fl_req_flush", mem_req, 1'b0); chk("fl_stn_flush", if_stall_nxt_pc, 1'b1); step();
    drive(1, 0, 0, 1, 1, 0, 64'h8000_0100, 32'h11); sample(); chk("fl_req_full", mem_req, 1'b0); step();
    drive(1, 0, 0, 1, 1, 0, 64'h8000_0100, 32'h22); sample();
    chk("fl_stale1_valid", if_parcel_valid, 2'b00);
    chk("fl_req_new", mem_req, 1'b1); chk("fl_adr_new", mem_adr, 64'h8000_0100); step();
    drive(1, 0, 0, 0, 0, 0, 64'h8000_0104, 0); sample();
    chk("fl_stale2_valid", if_parcel_valid, 2'b00);
    chk("fl_req_hold", mem_req, 1'b1); chk("fl_adr_hold", mem_adr, 64'h8000_0104); step();
    drive(1, 1, 0, 0, 1, 0, 64'h8000_0104, 32'h33); sample();
    chk("fl_req_stall", mem_req, 1'b1); chk("fl_adr_stall", mem_adr, 64'h8000_0104); step();
    drive(1, 0, 0, 0, 0, 0, 64'h8000_0104, 0); sample();
    chk("fl_valid", if_parcel_valid, 2'b11); chk("fl_ppc", if_parcel_pc, 64'h8000_0100);
    chk("fl_data", if_parcel, 32'h33); step();

    // Misaligned PC: one misaligned parcel, ERROR until flush
    do_reset();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0002, 0); sample();
    chk("mis_req", mem_req, 1'b0); chk("mis_stn", if_stall_nxt_pc, 1'b1); step();
    sample();
    chk("mis_valid", if_parcel_valid, 2'b11); chk("mis_flag", if_parcel_misaligned, 1'b1);
    chk("mis_ppc", if_parcel_pc, 64'h8000_0002); chk("mis_data", if_parcel, 32'h0);
    chk("mis_pf", if_parcel_page_fault, 1'b0); step();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0010, 0); sample();
    chk("mis_once", if_parcel_valid, 2'b00); chk("mis_err_req", mem_req, 1'b0); step();
    drive(1, 0, 1, 1, 0, 0, 64'h8000_0010, 0); sample(); chk("mis_flush_req", mem_req, 1'b0); step();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0010, 0); sample();
    chk("mis_resume_req", mem_req, 1'b1); chk("mis_resume_adr", mem_adr, 64'h8000_0010); step();

    // Held request across stall, then response error
    do_reset();
    drive(1, 0, 0, 0, 0, 0, 64'h8000_0000, 0); sample();
    chk("pf_req", mem_req, 1'b1); step();
    drive(1, 1, 0, 0, 0, 0, 64'h8000_0000, 0); sample();
    chk("pf_req_stall", mem_req, 1'b1); chk("pf_adr_stall", mem_adr, 64'h8000_0000);
    chk("pf_stn_stall", if_stall_nxt_pc, 1'b1); step();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0000, 0); sample();
    chk("pf_req_ack", mem_req, 1'b1); chk("pf_stn_ack", if_stall_nxt_pc, 1'b0); step();
    drive(1, 1, 0, 0, 1, 1, 64'h8000_0004, 32'h55); sample(); chk("pf_req_rsp", mem_req, 1'b0); step();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0004, 0); sample();
    chk("pf_valid", if_parcel_valid, 2'b11); chk("pf_flag", if_parcel_page_fault, 1'b1);
    chk("pf_ppc", if_parcel_pc, 64'h8000_0000); chk("pf_data", if_parcel, 32'h55);
    chk("pf_mis", if_parcel_misaligned, 1'b0); chk("pf_err_req", mem_req, 1'b0); step();
    sample(); chk("pf_err_req2", mem_req, 1'b0); step();
    drive(1, 0, 1, 1, 0, 0, 64'h8000_0004, 0); step();
    drive(1, 0, 0, 1, 0, 0, 64'h8000_0004, 0); sample();
    chk("pf_resume_req", mem_req, 1'b1); chk("pf_resume_adr", mem_adr, 64'h8000_0004); step();

    // Random traffic against the queue model
    do_reset();
    m_mode = M_FETCH; m_pcq.delete(); m_disc = 0; m_hold = 0; m_hadr = '0;
    e_v = '0; e_pc = '0; e_data = '0; e_mis = 0; e_pf = 0;
    fpc = 64'h8000_0000;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic r_rstn, r_st, r_fl, r_ak, r_rv, r_re;
      logic [31:0] r_rd;
      bit x_req, x_mis, x_errnow, x_acc, x_pop, x_live;
      logic [63:0] x_adr, popped;
      int sz0;
      r_rstn = ($urandom % 400) != 0;
      r_fl   = (m_mode == M_ERR) ? (($urandom % 4) == 0) : (($urandom % 24) == 0);
      r_st   = ($urandom % 4) == 0;
      r_ak   = ($urandom % 3) != 0;
      r_rv   = ($urandom % 3) == 0;
      r_re   = ($urandom % 20) == 0;
      r_rd   = $urandom;
      drive(r_rstn, r_st, r_fl, r_ak, r_rv, r_re, fpc, r_rd);
      sample();

      sz0      = m_pcq.size();
      x_errnow = r_rv && sz0 > 0 && m_disc == 0 && r_re;
      x_mis    = m_mode == M_FETCH && !m_hold && !r_fl && fpc[1:0] != 2'b00 && sz0 == m_disc;
      x_req    = (m_hold && !r_fl) ||
                 (m_mode == M_FETCH && !m_hold && !r_fl && !r_st && fpc[1:0] == 2'b00 &&
                  !x_errnow && sz0 < DEPTH);
      x_adr    = m_hold ? m_hadr : ((m_mode == M_FETCH) ? fpc : 64'h0);

      chk("rnd_req", mem_req, x_req);
      chk("rnd_adr", mem_adr, x_adr);
      chk("rnd_stall_nxt", if_stall_nxt_pc, !(x_req && r_ak));
      chk("rnd_valid", if_parcel_valid, e_v);
      chk("rnd_ppc", if_parcel_pc, e_pc);
      chk("rnd_parcel", if_parcel, e_data);
      chk("rnd_mis", if_parcel_misaligned, e_mis);
      chk("rnd_pf", if_parcel_page_fault, e_pf);
      step();

      x_acc  = x_req && r_ak;
      x_pop  = r_rv && sz0 > 0;
      popped = x_pop ? m_pcq.pop_front() : 64'h0;
      if (x_acc) m_pcq.push_back(x_adr);
      x_live = x_pop && m_disc == 0 && !r_fl;
      e_v = 2'b00;
      if (x_live) begin
        e_v = 2'b11; e_pc = popped; e_data = r_rd; e_pf = r_re; e_mis = 0;
      end else if (x_mis) begin
        e_v = 2'b11; e_pc = fpc; e_data = 0; e_pf = 0; e_mis = 1;
      end
      if (r_fl) m_disc = m_pcq.size();
      else if (x_pop && m_disc > 0) m_disc--;
      m_hold = x_req && !r_ak;
      if (x_req) m_hadr = x_adr;
      case (m_mode)
        M_IDLE:  m_mode = M_FETCH;
        M_FETCH: if (!r_fl && (x_mis || x_live && r_re)) m_mode = M_ERR;
        default: if (r_fl) m_mode = M_FETCH;
      endcase
      if (r_fl) begin
        int unsigned r;
        r   = $urandom_range(0, 16383);
        fpc = 64'h8000_0000 + 64'(r) * 64'd4;
        if (($urandom % 8) == 0) fpc = fpc + 64'd2;
      end else if (x_acc) begin
        fpc = fpc + 64'd4;
      end
      if (!r_rstn) begin
        m_mode = M_IDLE; m_pcq.delete(); m_disc = 0; m_hold = 0; m_hadr = '0;
        e_v = '0; e_pc = '0; e_data = '0; e_mis = 0; e_pf = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
